// File: rtl/edge_train_generator.sv
// edge_train_generator
//
// Emits a train of num_edges level transitions on dout, spaced half_period
// clock cycles apart (a half_period of 0 is treated as 1). A train is
// requested with start while idle and can be cancelled with abort.
//
// Ports
//   clk          - sole clock, rising edge
//   rst_n        - asynchronous active-low reset
//   start        - begin a train (sampled only while idle)
//   half_period  - cycles between edges, sampled with start
//   num_edges    - number of dout transitions, sampled with start
//   abort        - cancel an active train (no done pulse)
//   dout         - registered output waveform; holds its level between trains
//   edge_strobe  - high in the cycle dout shows a freshly toggled value
//   busy         - high while a train is active
//   done         - one-cycle pulse after a train completes normally
//   edges_left   - transitions still to be emitted
module edge_train_generator #(
    parameter int unsigned HP_W = 8,
    parameter int unsigned EC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [HP_W-1:0] half_period,
    input  logic [EC_W-1:0] num_edges,
    input  logic            abort,
    output logic            dout,
    output logic            edge_strobe,
    output logic            busy,
    output logic            done,
    output logic [EC_W-1:0] edges_left
);

    localparam logic [HP_W-1:0] HpOne = HP_W'(1);
    localparam logic [EC_W-1:0] EcOne = EC_W'(1);

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    state_e          state_q, state_d;
    logic [HP_W-1:0] hp_q, hp_d;
    logic [HP_W-1:0] cnt_q, cnt_d;
    logic [EC_W-1:0] edges_q, edges_d;
    logic            dout_q, dout_d;
    logic            strobe_q, strobe_d;
    logic            done_q, done_d;

    logic [HP_W-1:0] hp_eff;

    // A zero half period would never let the counter expire; clamp to 1.
    assign hp_eff = (half_period == '0) ? HpOne : half_period;

    always_comb begin
        state_d  = state_q;
        hp_d     = hp_q;
        cnt_d    = cnt_q;
        edges_d  = edges_q;
        dout_d   = dout_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // abort alongside start suppresses the request.
                if (start && !abort) begin
                    hp_d    = hp_eff;
                    edges_d = num_edges;
                    cnt_d   = hp_eff - HpOne;
                    if (num_edges == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end

            StRun: begin
                if (abort) begin
                    // Abort wins over a toggle due on the same edge.
                    state_d = StIdle;
                    edges_d = '0;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    dout_d   = ~dout_q;
                    strobe_d = 1'b1;
                    cnt_d    = hp_q - HpOne;
                    if (edges_q != '0) begin
                        edges_d = edges_q - EcOne;
                    end
                    if (edges_q <= EcOne) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - HpOne;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            hp_q     <= '0;
            cnt_q    <= '0;
            edges_q  <= '0;
            dout_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hp_q     <= hp_d;
            cnt_q    <= cnt_d;
            edges_q  <= edges_d;
            dout_q   <= dout_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

    assign dout        = dout_q;
    assign edge_strobe = strobe_q;
    assign busy        = (state_q == StRun);
    assign done        = done_q;
    assign edges_left  = edges_q;

endmodule

// File: tb/tb_edge_train_generator.sv
// Scoreboard bench for edge_train_generator. Stimulus pushes the expected
// strobe/done events (edge number, dout, edges_left); a monitor pops and
// compares whenever the DUT shows edge_strobe or done.
module tb_edge_train_generator;

    localparam int unsigned HP_W = 8;
    localparam int unsigned EC_W = 8;

    typedef struct {
        int              edge_n;
        logic            dout;
        logic            strb;
        logic            dn;
        logic [EC_W-1:0] left;
    } ev_t;

    logic            clk = 1'b0;
    bit              clk_en = 1'b1;
    logic            rst_n;
    logic            start;
    logic [HP_W-1:0] half_period;
    logic [EC_W-1:0] num_edges;
    logic            abort;
    logic            dout;
    logic            edge_strobe;
    logic            busy;
    logic            done;
    logic [EC_W-1:0] edges_left;

    int   cyc = 0;
    int   vec_n = 0;
    int   err_n = 0;
    logic exp_dout = 1'b0;
    ev_t  sb_q[$];
    ev_t  mon_e;

    edge_train_generator #(
        .HP_W(HP_W),
        .EC_W(EC_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .half_period(half_period),
        .num_edges  (num_edges),
        .abort      (abort),
        .dout       (dout),
        .edge_strobe(edge_strobe),
        .busy       (busy),
        .done       (done),
        .edges_left (edges_left)
    );

    // Clock can be frozen low by clearing clk_en.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: flags overdue expectations, then checks each presented event.
    always @(negedge clk) begin
        if (rst_n) begin
            while (sb_q.size() > 0 && sb_q[0].edge_n < cyc) begin
                mon_e = sb_q.pop_front();
                vec_n++;
                err_n++;
                $display("FAIL missed_event: expected at edge %0d, still pending at edge %0d",
                         mon_e.edge_n, cyc);
            end
            if (edge_strobe || done) begin
                vec_n++;
                if (sb_q.size() == 0) begin
                    err_n++;
                    $display("FAIL unexpected_event edge %0d: got dout=%b strobe=%b done=%b left=%0d, expected no event",
                             cyc, dout, edge_strobe, done, edges_left);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (mon_e.edge_n != cyc || mon_e.dout !== dout || mon_e.strb !== edge_strobe
                        || mon_e.dn !== done || mon_e.left !== edges_left) begin
                        err_n++;
                        $display("FAIL event: got edge=%0d dout=%b strobe=%b done=%b left=%0d, expected edge=%0d dout=%b strobe=%b done=%b left=%0d",
                                 cyc, dout, edge_strobe, done, edges_left, mon_e.edge_n,
                                 mon_e.dout, mon_e.strb, mon_e.dn, mon_e.left);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue start at the current negedge; the sampling edge is k = cyc+1.
    // Pushes the first push_n expected toggles (done only on the last of num).
    // Returns at the negedge following edge k with start dropped.
    task automatic launch(input int hp, input int num, input int push_n);
        int   k;
        int   hpe;
        ev_t  e;
        start       = 1'b1;
        half_period = HP_W'(hp);
        num_edges   = EC_W'(num);
        k   = cyc + 1;
        hpe = (hp == 0) ? 1 : hp;
        if (num == 0) begin
            e.edge_n = k; e.dout = exp_dout; e.strb = 1'b0; e.dn = 1'b1; e.left = '0;
            sb_q.push_back(e);
        end
        for (int i = 1; i <= push_n; i++) begin
            exp_dout = ~exp_dout;
            e.edge_n = k + i * hpe;
            e.dout   = exp_dout;
            e.strb   = 1'b1;
            e.dn     = (i == num);
            e.left   = EC_W'(num - i);
            sb_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sample from the current negedge until done, bounded by budget.
    task automatic wait_done(input int budget, output int busy_n, output int strb_n,
                             output bit ok);
        busy_n = 0;
        strb_n = 0;
        ok     = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (busy) busy_n++;
            if (edge_strobe) strb_n++;
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int bn;
        int sn;
        bit ok;
        int dn_cnt;

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        half_period = '0;
        num_edges = '0;
        repeat (3) @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_strobe", edge_strobe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_left", edges_left, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic train: hp=3, 4 edges -> toggles at k+3,6,9,12.
        launch(3, 4, 4);
        check("t1_busy_start", busy, 1);
        check("t1_left_start", edges_left, 4);
        wait_done(40, bn, sn, ok);
        check("t1_done_seen", ok, 1);
        check("t1_busy_cycles", bn, 12);
        check("t1_strobes", sn, 4);
        check("t1_final_dout", dout, 0);
        check("t1_busy_at_done", busy, 0);
        @(negedge clk);

        // Zero edges: done only, never busy, dout unchanged.
        launch(5, 0, 0);
        wait_done(5, bn, sn, ok);
        check("t2_done_seen", ok, 1);
        check("t2_busy_cycles", bn, 0);
        check("t2_strobes", sn, 0);
        check("t2_dout", dout, 0);
        @(negedge clk);
        check("t2_done_single", done, 0);

        // Abort on the edge where the 3rd toggle is due (k+12).
        launch(4, 6, 2);
        repeat (11) @(negedge clk);
        check("t4_busy_pre", busy, 1);
        check("t4_left_pre", edges_left, 4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_busy_after", busy, 0);
        check("t4_left_after", edges_left, 0);
        check("t4_dout_after", dout, 0);
        check("t4_no_strobe", edge_strobe, 0);
        dn_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) dn_cnt++;
            @(negedge clk);
        end
        check("t4_no_done", dn_cnt, 0);

        // Abort alone in idle, then abort together with start.
        abort = 1'b1;
        @(negedge clk);
        check("idle_abort_busy", busy, 0);
        check("idle_abort_done", done, 0);
        start = 1'b1;
        half_period = 8'd2;
        num_edges = 8'd3;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", busy, 0);
        check("start_abort_left", edges_left, 0);
        @(negedge clk);

        // half_period=0 behaves as 1: five consecutive toggles ending at 1.
        launch(0, 5, 5);
        wait_done(20, bn, sn, ok);
        check("t3_done_seen", ok, 1);
        check("t3_busy_cycles", bn, 5);
        check("t3_strobes", sn, 5);
        check("t3_final_dout", dout, 1);
        @(negedge clk);

        // start during RUN ignored, then back-to-back start in the done cycle.
        launch(2, 3, 3);
        @(negedge clk);
        start = 1'b1;
        half_period = 8'd7;
        num_edges = 8'd9;
        @(negedge clk);
        start = 1'b0;
        check("t5_left_mid", edges_left, 2);
        wait_done(20, bn, sn, ok);
        check("t5_done_seen", ok, 1);
        launch(1, 2, 2);
        check("t5_b2b_busy", busy, 1);
        check("t5_b2b_left", edges_left, 2);
        wait_done(20, bn, sn, ok);
        check("t5_b2b_done", ok, 1);
        check("t5_b2b_dout", dout, 0);
        @(negedge clk);

        // Asynchronous reset mid-train with the clock stopped.
        launch(3, 4, 4);
        repeat (4) @(negedge clk);
        check("t6_dout_pre", dout, 1);
        clk_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_dout", dout, 0);
        check("t6_rst_strobe", edge_strobe, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_left", edges_left, 0);
        sb_q.delete();
        exp_dout = 1'b0;
        #10;
        rst_n = 1'b1;
        #3;
        clk_en = 1'b1;
        launch(1, 1, 1);
        check("t6_first_edge_busy", busy, 1);
        check("t6_first_edge_left", edges_left, 1);
        wait_done(10, bn, sn, ok);
        check("t6_done_seen", ok, 1);
        check("t6_dout_final", dout, 1);

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end

endmodule
